viterbi_err_channel: RTL and testbench
======================================

VITERBI_ERR_CHANNEL -- requirements
Module: viterbi_err_channel

Interface
REQ-001 SHALL have parameter W, default 2, code-symbol width in bits (legal 1..8).
REQ-002 SHALL have parameter PERIOD_LOG2, default 3, log2 of the injection period in symbols (legal 1..8).
REQ-003 SHALL have parameter BURST_LEN, default 1, consecutive corrupted symbols per period (legal 1..2**PERIOD_LOG2).
REQ-004 SHALL have parameter WINDOW, default 256, symbols eligible for injection after start (legal 1..65535).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-007 SHALL have port enable_i  input  1  level; high runs the injection schedule.
REQ-008 SHALL have port clear_i  input  1  pulse; clears schedule position and counters.
REQ-009 SHALL have port valid_i  input  1  d_in carries a symbol this cycle.
REQ-010 SHALL have port d_in  input  W  encoder output symbol.
REQ-011 SHALL have port err_mask_i  input  W  bits to flip on an injected symbol.
REQ-012 SHALL have port valid_o  output  1  d_out carries a symbol.
REQ-013 SHALL have port d_out  output  W  possibly corrupted symbol, to decoder.
REQ-014 SHALL have port err_o  output  1  d_out symbol was corrupted.
REQ-015 SHALL have port inj_word_ct  output  16  corrupted symbols since clear.
REQ-016 SHALL have port bad_bit_ct  output  16  flipped bits since clear.
REQ-017 SHALL have port done_o  output  1  injection window exhausted.

Function
REQ-018 SHALL implement states IDLE, ACTIVE, DONE.
REQ-019 SHALL go IDLE->ACTIVE when enable_i=1, ACTIVE->DONE after the accepted symbol with index WINDOW-1, ACTIVE or DONE->IDLE when enable_i=0.
REQ-020 SHALL count accepted symbols (valid_i=1) in ACTIVE with a 16-bit index sym_ct from 0 and phase = sym_ct[PERIOD_LOG2-1:0].
REQ-021 SHALL corrupt a symbol only in ACTIVE and when phase >= 2**PERIOD_LOG2-BURST_LEN.
REQ-022 SHALL register outputs with latency 1: valid_o=valid_i, d_out=d_in^(inject?err_mask_i:0), err_o=inject&&valid_i.
REQ-023 SHALL hold d_out and force err_o=0 when valid_i=0; sym_ct, phase and counters do not advance.
REQ-024 SHALL pass symbols unmodified in IDLE and DONE.
REQ-025 SHALL add 1 to inj_word_ct and popcount(err_mask_i) to bad_bit_ct per corrupted symbol, each saturating at 16'hFFFF.
REQ-026 SHALL count a corrupted symbol with err_mask_i=0 in inj_word_ct and add 0 to bad_bit_ct.
REQ-027 SHALL on clear_i=1 zero sym_ct and both counters and re-enter ACTIVE if enable_i=1, else IDLE.
REQ-028 SHALL, when clear_i and an injection coincide, still corrupt the data while counters read 0 next cycle.
REQ-029 SHALL retain sym_ct and counters on enable_i=0 and resume at that position when re-enabled without clear_i.
REQ-030 SHALL drive done_o=1 exactly while in DONE.

Reset
REQ-031 SHALL, on rst=0 at a clock edge, enter IDLE with sym_ct=0 and all outputs 0.
REQ-032 SHALL let reset override enable_i and clear_i, and discard any in-flight symbol.

Configuration
REQ-033 SHALL, with macro VITERBI_ERR_RAND_EN defined, add 16-bit LFSR x^16+x^14+x^13+x^11+1, seed 16'hABCD on reset or clear_i, stepping once per accepted ACTIVE symbol.
REQ-034 SHALL, with VITERBI_ERR_RAND_EN, replace REQ-021: inject when the current LFSR[PERIOD_LOG2-1:0]==0, BURST_LEN ignored.
REQ-035 SHALL, without VITERBI_ERR_RAND_EN, contain no LFSR and use only the periodic schedule.

Verification
REQ-036 SHALL verify: rst=0 for 2 cycles with enable_i=1 -> all outputs 0, state IDLE.
REQ-037 SHALL verify: defaults, continuous valid_i, d_in=2'b00, mask=2'b01 -> d_out=2'b01 at symbols 7,15,...,255; inj_word_ct=32, bad_bit_ct=32, done_o=1 after symbol 255.
REQ-038 SHALL verify: BURST_LEN=3, mask=2'b11 -> symbols 5,6,7 of each 8 corrupted; bad_bit_ct=192 at done_o.
REQ-039 SHALL verify: valid_i high every other cycle -> same corrupted symbol indices as REQ-037; counters unchanged on idle cycles.
REQ-040 SHALL verify: enable_i dropped after symbol 100 for 10 cycles, then clear_i at symbol 200 -> counters 12 during the pause, 0 after clear, next injection at new index 7.
REQ-041 SHALL verify: VITERBI_ERR_RAND_EN defined -> corrupted indices and counters match a reference LFSR model over 256 symbols.

Source files
------------

// File: rtl/viterbi_err_channel.sv
// Error-injection channel between a convolutional encoder and a Viterbi decoder.
// Optional macro VITERBI_ERR_RAND_EN swaps the periodic burst schedule for an LFSR schedule.
module viterbi_err_channel #(
  parameter int W           = 2,
  parameter int PERIOD_LOG2 = 3,
  parameter int BURST_LEN   = 1,
  parameter int WINDOW      = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable_i,
  input  logic         clear_i,
  input  logic         valid_i,
  input  logic [W-1:0] d_in,
  input  logic [W-1:0] err_mask_i,
  output logic         valid_o,
  output logic [W-1:0] d_out,
  output logic         err_o,
  output logic [15:0]  inj_word_ct,
  output logic [15:0]  bad_bit_ct,
  output logic         done_o
);

  localparam int PERIOD = 1 << PERIOD_LOG2;
  localparam int THRESH = PERIOD - BURST_LEN;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [15:0]            sym_ct_reg;
  logic [PERIOD_LOG2-1:0] phase;
  logic                   accept;
  logic                   inject;
  logic [3:0]             mask_pop;
  logic [16:0]            bad_sum;

  assign phase  = sym_ct_reg[PERIOD_LOG2-1:0];
  assign accept = (state_reg == ACTIVE) && valid_i;
  assign done_o = (state_reg == DONE);

`ifdef VITERBI_ERR_RAND_EN
  logic [15:0] lfsr_reg;
  logic        lfsr_fb;

  // Fibonacci form of x^16+x^14+x^13+x^11+1.
  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign inject  = accept && (lfsr_reg[PERIOD_LOG2-1:0] == '0);

  always_ff @(posedge clk) begin
    if (!rst || clear_i) begin
      lfsr_reg <= 16'hABCD;
    end else if (accept) begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
    end
  end
`else
  // The last BURST_LEN phases of every period are corrupted.
  assign inject = accept && (int'(phase) >= THRESH);
`endif

  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < W; i++) begin
      mask_pop = mask_pop + 4'(err_mask_i[i]);
    end
  end

  assign bad_sum = {1'b0, bad_bit_ct} + 17'(mask_pop);

  always_comb begin
    state_next = state_reg;
    if (clear_i) begin
      state_next = enable_i ? ACTIVE : IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (enable_i) state_next = ACTIVE;
        ACTIVE: begin
          if (!enable_i) begin
            state_next = IDLE;
          end else if (valid_i && sym_ct_reg == 16'(WINDOW - 1)) begin
            state_next = DONE;
          end
        end
        DONE:    if (!enable_i) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      sym_ct_reg  <= '0;
      valid_o     <= 1'b0;
      d_out       <= '0;
      err_o       <= 1'b0;
      inj_word_ct <= '0;
      bad_bit_ct  <= '0;
    end else begin
      state_reg <= state_next;
      valid_o   <= valid_i;
      err_o     <= inject;
      if (valid_i) begin
        d_out <= d_in ^ (inject ? err_mask_i : '0);
      end
      // Clear wins over a coincident injection: data is corrupted, counters restart at 0.
      if (clear_i) begin
        sym_ct_reg  <= '0;
        inj_word_ct <= '0;
        bad_bit_ct  <= '0;
      end else if (accept) begin
        sym_ct_reg <= sym_ct_reg + 16'd1;
        if (inject) begin
          if (inj_word_ct != 16'hFFFF) inj_word_ct <= inj_word_ct + 16'd1;
          bad_bit_ct <= bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_viterbi_err_channel.sv
// Directed bench for viterbi_err_channel: defaults plus a BURST_LEN=3 instance on shared inputs.
module tb_viterbi_err_channel;

  logic        clk = 1'b0;
  logic        rst, enable_i, clear_i, valid_i;
  logic [1:0]  d_in, err_mask_i;
  logic        valid_o, err_o, done_o;
  logic [1:0]  d_out;
  logic [15:0] inj_word_ct, bad_bit_ct;
  logic        valid_o_b, err_o_b, done_o_b;
  logic [1:0]  d_out_b;
  logic [15:0] inj_word_ct_b, bad_bit_ct_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  viterbi_err_channel dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .clear_i(clear_i), .valid_i(valid_i),
    .d_in(d_in), .err_mask_i(err_mask_i), .valid_o(valid_o), .d_out(d_out), .err_o(err_o),
    .inj_word_ct(inj_word_ct), .bad_bit_ct(bad_bit_ct), .done_o(done_o)
  );

  viterbi_err_channel #(.BURST_LEN(3)) dut_b (
    .clk(clk), .rst(rst), .enable_i(enable_i), .clear_i(clear_i), .valid_i(valid_i),
    .d_in(d_in), .err_mask_i(err_mask_i), .valid_o(valid_o_b), .d_out(d_out_b), .err_o(err_o_b),
    .inj_word_ct(inj_word_ct_b), .bad_bit_ct(bad_bit_ct_b), .done_o(done_o_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable_i = 1'b1; clear_i = 1'b1; valid_i = 1'b1; d_in = 2'b11; err_mask_i = 2'b11;
    step(); step();
    if ({valid_o, d_out, err_o, done_o} !== 5'b0) begin
      n_bad++; $display("FAIL reset_outs got %b exp 00000", {valid_o, d_out, err_o, done_o});
    end
    n_cmp++;
    if ({inj_word_ct, bad_bit_ct} !== 32'h0) begin
      n_bad++; $display("FAIL reset_cnts got %h exp 0", {inj_word_ct, bad_bit_ct});
    end
    n_cmp++;
    $display("reset: outs=%b cnts=%h", {valid_o, d_out, err_o, done_o}, {inj_word_ct, bad_bit_ct});
    rst = 1'b1; clear_i = 1'b0; valid_i = 1'b0; enable_i = 1'b0;
    step();
  endtask

`ifndef VITERBI_ERR_RAND_EN
  task automatic test_periodic();
    logic exp_inj;
    clear_i = 1'b1; enable_i = 1'b1; valid_i = 1'b0; step();
    clear_i = 1'b0; d_in = 2'b00; err_mask_i = 2'b01;
    for (int i = 0; i < 256; i++) begin
      valid_i = 1'b1; step();
      exp_inj = (i % 8) == 7;
      if (d_out !== {1'b0, exp_inj} || err_o !== exp_inj) begin
        n_bad++; $display("FAIL periodic_sym%0d got d=%b e=%b exp d=%b e=%b", i, d_out, err_o, {1'b0, exp_inj}, exp_inj);
      end
      n_cmp++;
      $display("periodic sym %0d d_out=%b err=%b", i, d_out, err_o);
      if (i == 254 && done_o !== 1'b0) begin
        n_bad++; $display("FAIL early_done got %b exp 0", done_o);
      end
    end
    n_cmp++;
    if (inj_word_ct !== 16'd32 || bad_bit_ct !== 16'd32 || done_o !== 1'b1) begin
      n_bad++; $display("FAIL periodic_end got inj=%0d bad=%0d done=%b exp 32 32 1", inj_word_ct, bad_bit_ct, done_o);
    end
    n_cmp++;
    for (int i = 0; i < 8; i++) begin
      step();
      if (err_o !== 1'b0 || d_out !== 2'b00) begin
        n_bad++; $display("FAIL done_pass%0d got d=%b e=%b exp 00 0", i, d_out, err_o);
      end
      n_cmp++;
    end
    if (inj_word_ct !== 16'd32 || done_o !== 1'b1) begin
      n_bad++; $display("FAIL done_hold got inj=%0d done=%b exp 32 1", inj_word_ct, done_o);
    end
    n_cmp++;
    valid_i = 1'b0;
  endtask

  task automatic test_burst();
    logic exp_b;
    enable_i = 1'b0; valid_i = 1'b0; step();
    if (done_o !== 1'b0) begin
      n_bad++; $display("FAIL done_drop got %b exp 0", done_o);
    end
    n_cmp++;
    enable_i = 1'b1; clear_i = 1'b1; step();
    clear_i = 1'b0; d_in = 2'b00; err_mask_i = 2'b11;
    for (int i = 0; i < 256; i++) begin
      valid_i = 1'b1; step();
      exp_b = (i % 8) >= 5;
      if (err_o_b !== exp_b || d_out_b !== {exp_b, exp_b}) begin
        n_bad++; $display("FAIL burst_sym%0d got d=%b e=%b exp e=%b", i, d_out_b, err_o_b, exp_b);
      end
      n_cmp++;
      $display("burst sym %0d d_out=%b err=%b", i, d_out_b, err_o_b);
    end
    if (inj_word_ct_b !== 16'd96 || bad_bit_ct_b !== 16'd192 || done_o_b !== 1'b1) begin
      n_bad++; $display("FAIL burst_end got inj=%0d bad=%0d done=%b exp 96 192 1", inj_word_ct_b, bad_bit_ct_b, done_o_b);
    end
    n_cmp++;
    if (inj_word_ct !== 16'd32 || bad_bit_ct !== 16'd64) begin
      n_bad++; $display("FAIL burst_dflt got inj=%0d bad=%0d exp 32 64", inj_word_ct, bad_bit_ct);
    end
    n_cmp++;
    valid_i = 1'b0;
  endtask

  task automatic test_gaps();
    logic       exp_inj;
    logic [1:0] exp_d;
    int         exp_cnt = 0;
    enable_i = 1'b0; step();
    enable_i = 1'b1; clear_i = 1'b1; valid_i = 1'b0; step();
    clear_i = 1'b0; err_mask_i = 2'b01;
    for (int i = 0; i < 256; i++) begin
      valid_i = 1'b1; d_in = 2'(i); step();
      exp_inj = (i % 8) == 7;
      exp_d = 2'(i) ^ {1'b0, exp_inj};
      if (exp_inj) exp_cnt++;
      if (d_out !== exp_d || err_o !== exp_inj || inj_word_ct !== 16'(exp_cnt)) begin
        n_bad++; $display("FAIL gap_sym%0d got d=%b e=%b c=%0d exp %b %b %0d", i, d_out, err_o, inj_word_ct, exp_d, exp_inj, exp_cnt);
      end
      n_cmp++;
      valid_i = 1'b0; d_in = 2'b11; step();
      if (valid_o !== 1'b0 || err_o !== 1'b0 || d_out !== exp_d || inj_word_ct !== 16'(exp_cnt)) begin
        n_bad++; $display("FAIL gap_idle%0d got v=%b e=%b d=%b c=%0d exp 0 0 %b %0d", i, valid_o, err_o, d_out, inj_word_ct, exp_d, exp_cnt);
      end
      n_cmp++;
      $display("gap sym %0d d_out=%b err=%b cnt=%0d", i, exp_d, exp_inj, exp_cnt);
    end
    if (inj_word_ct !== 16'd32 || bad_bit_ct !== 16'd32 || done_o !== 1'b1) begin
      n_bad++; $display("FAIL gap_end got inj=%0d bad=%0d done=%b exp 32 32 1", inj_word_ct, bad_bit_ct, done_o);
    end
    n_cmp++;
  endtask

  task automatic test_pause_clear();
    logic exp_inj;
    enable_i = 1'b0; valid_i = 1'b0; step();
    enable_i = 1'b1; clear_i = 1'b1; step();
    clear_i = 1'b0; d_in = 2'b00; err_mask_i = 2'b01;
    for (int i = 0; i <= 100; i++) begin
      valid_i = 1'b1; step();
    end
    enable_i = 1'b0; valid_i = 1'b0; step();
    for (int i = 0; i < 9; i++) begin
      valid_i = 1'b1; step();
      if (err_o !== 1'b0 || d_out !== 2'b00 || inj_word_ct !== 16'd12 || bad_bit_ct !== 16'd12) begin
        n_bad++; $display("FAIL pause%0d got e=%b d=%b inj=%0d bad=%0d exp 0 00 12 12", i, err_o, d_out, inj_word_ct, bad_bit_ct);
      end
      n_cmp++;
      $display("pause cycle %0d inj=%0d", i, inj_word_ct);
    end
    enable_i = 1'b1; valid_i = 1'b0; step();
    for (int i = 101; i < 200; i++) begin
      valid_i = 1'b1; step();
      exp_inj = (i % 8) == 7;
      if (err_o !== exp_inj) begin
        n_bad++; $display("FAIL resume_sym%0d got %b exp %b", i, err_o, exp_inj);
      end
      n_cmp++;
    end
    if (inj_word_ct !== 16'd25) begin
      n_bad++; $display("FAIL resume_cnt got %0d exp 25", inj_word_ct);
    end
    n_cmp++;
    clear_i = 1'b1; step(); clear_i = 1'b0;
    if (inj_word_ct !== 16'd0 || bad_bit_ct !== 16'd0) begin
      n_bad++; $display("FAIL clear_cnt got %0d %0d exp 0 0", inj_word_ct, bad_bit_ct);
    end
    n_cmp++;
    for (int i = 0; i < 15; i++) begin
      step();
      exp_inj = (i % 8) == 7;
      if (err_o !== exp_inj) begin
        n_bad++; $display("FAIL postclr_sym%0d got %b exp %b", i, err_o, exp_inj);
      end
      n_cmp++;
      $display("post-clear sym %0d err=%b", i, err_o);
    end
    // Index 15 injects on the same edge as clear: data corrupted, counters restart.
    clear_i = 1'b1; step(); clear_i = 1'b0; valid_i = 1'b0;
    if (err_o !== 1'b1 || d_out !== 2'b01 || inj_word_ct !== 16'd0 || bad_bit_ct !== 16'd0) begin
      n_bad++; $display("FAIL clr_inject got e=%b d=%b inj=%0d bad=%0d exp 1 01 0 0", err_o, d_out, inj_word_ct, bad_bit_ct);
    end
    n_cmp++;
  endtask
`else
  task automatic test_rand();
    logic [15:0] lf = 16'hABCD;
    logic        exp_inj;
    int          exp_cnt = 0;
    enable_i = 1'b1; clear_i = 1'b1; valid_i = 1'b0; step();
    clear_i = 1'b0; d_in = 2'b00; err_mask_i = 2'b01;
    for (int i = 0; i < 256; i++) begin
      valid_i = 1'b1; step();
      exp_inj = (lf[2:0] == 3'b000);
      if (exp_inj) exp_cnt++;
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
      if (err_o !== exp_inj || inj_word_ct !== 16'(exp_cnt)) begin
        n_bad++; $display("FAIL rand_sym%0d got e=%b c=%0d exp %b %0d", i, err_o, inj_word_ct, exp_inj, exp_cnt);
      end
      n_cmp++;
      $display("rand sym %0d err=%b cnt=%0d", i, err_o, inj_word_ct);
    end
    if (bad_bit_ct !== 16'(exp_cnt) || done_o !== 1'b1) begin
      n_bad++; $display("FAIL rand_end got bad=%0d done=%b exp %0d 1", bad_bit_ct, done_o, exp_cnt);
    end
    n_cmp++;
  endtask
`endif

  initial begin
    test_reset();
`ifndef VITERBI_ERR_RAND_EN
    test_periodic();
    test_burst();
    test_gaps();
    test_pause_clear();
`else
    test_rand();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
